// File: rtl/func_gen_pkg.sv
// Shared waveform-generator definitions: waveform types, per-type step counts,
// per-type count limits and the power-on step count.
package func_gen_pkg;

  typedef enum logic [2:0] {
    SINE     = 3'd0,
    TRIANGLE = 3'd1,
    SQUARE   = 3'd2,
    PWM      = 3'd3,
    PATTERN  = 3'd4
  } signal_t;

  typedef enum logic [1:0] {IDLE, PREP, DIV, FIN} cfg_state_t;

  localparam logic [31:0] STEPS_SQUARE  = 32'd2;
  localparam logic [31:0] STEPS_PWM     = 32'd256;
  localparam logic [31:0] STEPS_PATTERN = 32'd16;

  localparam logic [31:0] LIMIT_WAVE    = 32'd9999;
  localparam logic [31:0] LIMIT_PATTERN = 32'd62499;
  localparam logic [31:0] LIMIT_PULSE   = 32'd499999;

  localparam logic [31:0] RESET_COUNT   = 32'd999;

  // LUT-based waveforms use the configurable sample count.
  function automatic logic [31:0] step_count(input logic [2:0] t, input logic [31:0] samples);
    case (t)
      SQUARE:  return STEPS_SQUARE;
      PWM:     return STEPS_PWM;
      PATTERN: return STEPS_PATTERN;
      default: return samples;
    endcase
  endfunction

  function automatic logic [31:0] upper_limit(input logic [2:0] t);
    case (t)
      SINE, TRIANGLE: return LIMIT_WAVE;
      PATTERN:        return LIMIT_PATTERN;
      default:        return LIMIT_PULSE;
    endcase
  endfunction

endpackage

// File: rtl/udiv32.sv
// 32-bit unsigned serial restoring divider, one quotient bit per clock.
// The start edge performs the first of the 32 iterations; done pulses after the last.
module udiv32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] rem;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic        run;
  logic [63:0] nxt;

  // Returns {remainder, quotient} after shifting in one dividend bit.
  function automatic logic [63:0] div_step(input logic [31:0] r, input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] trial;
    logic [32:0] diff;
    trial = {r, q[31]};
    diff  = trial - {1'b0, d};
    if (!diff[32]) return {diff[31:0], q[30:0], 1'b1};
    return {trial[31:0], q[30:0], 1'b0};
  endfunction

  assign nxt = div_step(start ? 32'd0 : rem, start ? dividend : quotient, start ? divisor : dvs);

  always_ff @(posedge clk) begin
    if (start || run) {rem, quotient} <= nxt;
    if (start) dvs <= divisor;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run  <= 1'b0;
      cnt  <= 5'd0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        cnt <= 5'd1;
      end else if (run) begin
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wave_cfg.sv
// Converts a requested output frequency and waveform type into the per-step
// clock count: floor(CLK_HZ / (freq * steps)) - 1, limited per waveform type.
module wave_cfg
  import func_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SAMPLES = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] freq_hz,
  input  logic [2:0]  sig_type,
  output logic [31:0] set_count,
  output logic [2:0]  sig_type_out,
  output logic        cfg_valid,
  output logic        clamped,
  output logic        err,
  output logic        busy
);

  cfg_state_t  state;
  logic [23:0] freq_q;
  logic [2:0]  type_q;
  logic [31:0] den;
  logic [31:0] quo;
  logic        div_start;
  logic        div_done;
  logic        bad_req;

  // Returns {clamped, count}; a zero quotient cannot be decremented.
  function automatic logic [32:0] saturate(input logic [31:0] q, input logic [31:0] lim);
    if (q == 32'd0) return {1'b1, 32'd0};
    if ((q - 32'd1) > lim) return {1'b1, lim};
    return {1'b0, q - 32'd1};
  endfunction

  assign req_ready = (state == IDLE) && rst_n;
  assign bad_req   = (freq_q == 24'd0) || (type_q > 3'(PATTERN));
  assign den       = 32'(freq_q) * step_count(type_q, 32'(SAMPLES));
  assign div_start = (state == PREP) && !bad_req;

  udiv32 u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (32'(CLK_HZ)),
    .divisor  (den),
    .done     (div_done),
    .quotient (quo)
  );

  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      freq_q <= freq_hz;
      type_q <= sig_type;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      set_count    <= RESET_COUNT;
      sig_type_out <= SINE;
      cfg_valid    <= 1'b0;
      err          <= 1'b0;
      clamped      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          busy  <= 1'b1;
          state <= PREP;
        end
        PREP: if (bad_req) begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          state <= DIV;
        end
        DIV: if (div_done) state <= FIN;
        FIN: begin
          {clamped, set_count} <= saturate(quo, upper_limit(type_q));
          sig_type_out <= type_q;
          cfg_valid    <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wave_cfg.md
WAVE_CFG -- requirements
Module: wave_cfg

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz (32-bit).
REQ-002 Parameter SAMPLES, default 100, LUT points per period for SINE and TRIANGLE.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low; clock clk.
REQ-005 req_valid  input  1  new frequency/type request present.
REQ-006 req_ready  output  1  block idle and able to accept a request.
REQ-007 freq_hz  input  24  requested output frequency in Hz.
REQ-008 sig_type  input  3  requested waveform (signal_t: SINE=0, TRIANGLE=1, SQUARE=2, PWM=3, PATTERN=4).
REQ-009 set_count  output  32  per-step clock count consumed by the waveform generator.
REQ-010 sig_type_out  output  3  waveform type matching set_count.
REQ-011 cfg_valid  output  1  one-cycle pulse: set_count and sig_type_out just updated.
REQ-012 clamped  output  1  last accepted result was limited to a range bound; held until next result.
REQ-013 err  output  1  one-cycle pulse: request rejected.
REQ-014 busy  output  1  conversion in progress.

Function
REQ-015 Handshake: request accepted on edge E0 where req_valid && req_ready; freq_hz and sig_type latched at E0; req_ready = (state == IDLE) && rst_n.
REQ-016 req_valid while busy is ignored; no queueing.
REQ-017 Steps per period: SINE/TRIANGLE SAMPLES, SQUARE 2, PWM 256, PATTERN 16.
REQ-018 Denominator = freq_hz * steps, 32-bit unsigned, computed in PREP; no overflow possible (max 0xFFFFFF*256).
REQ-019 Quotient q = floor(CLK_HZ / denominator), 32-bit unsigned restoring division, one quotient bit per cycle, 32 iterations.
REQ-020 Result r = q - 1 if q >= 1; r = 0 with clamped = 1 if q == 0.
REQ-021 Upper limits: SINE/TRIANGLE 9999, PATTERN 62499, SQUARE/PWM 499999; r > limit -> r = limit, clamped = 1; r == limit -> not clamped.
REQ-022 FSM states IDLE -> PREP (1 cycle) -> DIV (32 iterations) -> FIN (1 cycle) -> IDLE.
REQ-023 Latency: set_count, sig_type_out, clamped update at edge E34; cfg_valid high for exactly the cycle after E34; req_ready high again after E34.
REQ-024 busy high from after E0 until after E34.
REQ-025 Rejection: freq_hz == 0 or sig_type > 4 -> IDLE -> FIN path skipped; err high for the cycle after E1; set_count, sig_type_out, clamped unchanged; no cfg_valid; req_ready high after E1.
REQ-026 cfg_valid and err never high in the same cycle.
REQ-027 Back-to-back: a request presented in the cycle req_ready returns high is accepted on that edge.

Reset
REQ-028 While rst_n low at an edge: state IDLE, set_count = 999, sig_type_out = SINE, cfg_valid = 0, err = 0, clamped = 0, busy = 0.
REQ-029 Reset mid-conversion aborts it; no cfg_valid or err is produced for the aborted request.
REQ-030 req_ready low while rst_n low; high in the first cycle after rst_n returns high.

Structure
REQ-031 Package func_gen_pkg holds signal_t, the per-type step counts, the per-type upper limits and the reset count 999; func_gen and wave_cfg both import it.
REQ-032 Division lives in sub-module udiv32: start/done handshake, 32-bit dividend/divisor, 32-cycle serial restoring divider.

Verification
REQ-033 SINE, freq_hz 1000 -> set_count 999, clamped 0, cfg_valid the cycle after E34.
REQ-034 PWM 1000 -> 389; PATTERN 100 -> 62499 clamped 0; SQUARE 50 -> 499999 clamped 1; SINE 2_000_000 -> 0 clamped 1.
REQ-035 sig_type 5, then freq_hz 0 -> err pulse after E1 each time; set_count keeps its prior value; no cfg_valid.
REQ-036 Second req_valid held during busy -> ignored until req_ready; accepted on the first ready edge; result follows 34 cycles later.
REQ-037 rst_n low at E10 of a SQUARE 50 request -> set_count 999, sig_type_out SINE, no cfg_valid; a new request after release completes normally.
